// File: rtl/mem_load_writer.sv
// Small register-file memory with single writes and a sequential burst fill
// (IDLE -> LOAD -> DONE), combinational read port and async active-low reset.
module mem_load_writer #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             load_start,
   output logic             load_busy,
   output logic             load_done,
   input  logic [AW-1:0]    addr,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       dbg_state
);

   // Handshake: a beat transfers on a rising edge where wr_valid && wr_ready;
   // wr_ready does not depend on wr_valid, and is low in reset and in DONE.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t           state, state_nx;
   logic [AW-1:0]    cnt, cnt_nx;
   logic             run;
   logic             xfer;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] mem [DEPTH];

   // run holds wr_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         run   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         run   <= 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         S_IDLE: begin
            if (run && load_start) begin
               state_nx = S_LOAD;
               cnt_nx   = '0;
               // a beat offered alongside load_start is burst beat 0
               if (xfer) begin
                  if (LAST == '0) state_nx = S_DONE;
                  else            cnt_nx   = AW'(1);
               end
            end
         end
         S_LOAD: begin
            if (xfer) begin
               if (cnt == LAST) begin
                  state_nx = S_DONE;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + AW'(1);
               end
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ready  = 1'b0;
      load_busy = 1'b0;
      load_done = 1'b0;
      case (state)
         S_IDLE: wr_ready = run;
         S_LOAD: begin
            wr_ready  = 1'b1;
            load_busy = 1'b1;
         end
         S_DONE:  load_done = 1'b1;
         default: wr_ready  = 1'b0;
      endcase
   end

   assign xfer = wr_valid && wr_ready;

   always_comb begin
      waddr = wr_addr;
      if (state == S_LOAD)                 waddr = cnt;
      else if (state == S_IDLE && load_start) waddr = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (xfer) begin
         mem[waddr] <= wr_data;
      end
   end

   assign dout      = mem[addr];
   assign dbg_state = state;

endmodule

// File: tb/tb_mem_load_writer.sv
// Directed bench for mem_load_writer: single writes, bursts with and without
// gaps, load_start colliding with a beat, and reset in the middle of a burst.
`timescale 1ns/100ps
module tb_mem_load_writer;

   localparam int DEPTH = 8;
   localparam int WIDTH = 8;
   localparam int AW    = 3;

   logic             clk;
   logic             rst_n;
   logic             wr_valid;
   logic             wr_ready;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             load_start;
   logic             load_busy;
   logic             load_done;
   logic [AW-1:0]    addr;
   logic [WIDTH-1:0] dout;
   logic [1:0]       dbg_state;

   int n_assert = 0;
   int n_fail   = 0;
   logic [WIDTH-1:0] exp_mem [DEPTH];

   mem_load_writer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .load_start (load_start),
      .load_busy  (load_busy),
      .load_done  (load_done),
      .addr       (addr),
      .dout       (dout),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_flags(input string tag, input logic rdy, input logic busy, input logic done);
      check({tag, " wr_ready"},  {31'd0, wr_ready},  {31'd0, rdy});
      check({tag, " load_busy"}, {31'd0, load_busy}, {31'd0, busy});
      check({tag, " load_done"}, {31'd0, load_done}, {31'd0, done});
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         addr = AW'(i);
         #0.5;
         check($sformatf("%s dout[%0d]", tag, i), {24'd0, dout}, {24'd0, exp_mem[i]});
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
   endtask

   // back-to-back burst; data = base + beat index
   task automatic burst(input string tag, input logic [7:0] base);
      load_start = 1'b1;
      check_flags({tag, " start"}, 1'b1, 1'b0, 1'b0);
      cycle();
      load_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         check_flags($sformatf("%s beat%0d", tag, i), 1'b1, 1'b1, 1'b0);
         wr_valid = 1'b1;
         wr_addr  = AW'($urandom_range(0, DEPTH - 1));
         wr_data  = base + 8'(i);
         exp_mem[i] = base + 8'(i);
         cycle();
      end
      wr_valid = 1'b0;
      check_flags({tag, " done"}, 1'b0, 1'b0, 1'b1);
      check({tag, " state done"}, {30'd0, dbg_state}, 32'd2);
      cycle();
      check_flags({tag, " after"}, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin : stim
      logic [15:0] pat;
      int beat;

      rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      load_start = 1'b0; addr = '0;
      clear_model();

      // reset state
      #2;
      check_flags("reset", 1'b0, 1'b0, 1'b0);
      check("reset dout", {24'd0, dout}, 32'd0);
      check("reset state", {30'd0, dbg_state}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("ready before edge", {31'd0, wr_ready}, 32'd0);
      cycle();
      check("ready after edge", {31'd0, wr_ready}, 32'd1);

      // single writes
      wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; cycle();
      wr_addr = 3'd7; wr_data = 8'h5A; cycle();
      wr_valid = 1'b0;
      exp_mem[3] = 8'hA5; exp_mem[7] = 8'h5A;
      check_mem("single");

      // write-while-read: old value until the edge
      cycle();
      addr = 3'd2; wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 8'h3C;
      #1;
      check("rdw before", {24'd0, dout}, 32'h00);
      cycle();
      wr_valid = 1'b0;
      check("rdw after", {24'd0, dout}, 32'h3C);
      exp_mem[2] = 8'h3C;

      // back-to-back burst
      burst("burst", 8'h10);
      check_mem("burst");

      // load_start during LOAD and DONE is ignored
      load_start = 1'b1; cycle();
      load_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         load_start = (i == 3);
         wr_valid = 1'b1; wr_data = 8'h20 + 8'(i); exp_mem[i] = 8'h20 + 8'(i);
         cycle();
      end
      wr_valid = 1'b0;
      check("restart ignored done", {31'd0, load_done}, 32'd1);
      load_start = 1'b1;
      cycle();
      load_start = 1'b0;
      check("start in done", {30'd0, dbg_state}, 32'd0);
      check("done one cycle", {31'd0, load_done}, 32'd0);
      check_mem("restart");

      // reset clears contents, then burst with valid gaps and random wr_addr
      rst_n = 1'b0; #1;
      clear_model();
      check_mem("reset2");
      cycle(); rst_n = 1'b1; cycle();
      pat = 16'b0110_1011_0001_1010;
      beat = 0;
      load_start = 1'b1; cycle(); load_start = 1'b0;
      for (int c = 1; c < 16 && beat < DEPTH; c++) begin
         check_flags($sformatf("gap c%0d", c), 1'b1, 1'b1, 1'b0);
         wr_valid = pat[c];
         wr_addr  = AW'($urandom_range(0, DEPTH - 1));
         wr_data  = 8'h10 + 8'(beat);
         if (pat[c]) begin
            exp_mem[beat] = 8'h10 + 8'(beat);
            beat++;
         end
         cycle();
      end
      wr_valid = 1'b0;
      check_flags("gap done", 1'b0, 1'b0, 1'b1);
      cycle();
      check_mem("gap");

      // load_start with a concurrent beat
      load_start = 1'b1; wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 8'hEE;
      exp_mem[0] = 8'hEE;
      cycle();
      load_start = 1'b0;
      check("concurrent cnt", {30'd0, dbg_state}, 32'd1);
      for (int i = 1; i < DEPTH; i++) begin
         check_flags($sformatf("conc beat%0d", i), 1'b1, 1'b1, 1'b0);
         wr_addr = 3'd0; wr_data = 8'h40 + 8'(i); exp_mem[i] = 8'h40 + 8'(i);
         cycle();
      end
      wr_valid = 1'b0;
      check_flags("conc done", 1'b0, 1'b0, 1'b1);
      cycle();
      check_mem("conc");

      // reset after 4 burst beats
      load_start = 1'b1; cycle(); load_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_data = 8'h50 + 8'(i); cycle();
      end
      wr_valid = 1'b0;
      rst_n = 1'b0; #1;
      clear_model();
      check_flags("midrst", 1'b0, 1'b0, 1'b0);
      check("midrst state", {30'd0, dbg_state}, 32'd0);
      check_mem("midrst");
      cycle();
      check_flags("midrst hold", 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1; #1;
      check("midrst ready pre", {31'd0, wr_ready}, 32'd0);
      cycle();
      check_flags("midrst out", 1'b1, 1'b0, 1'b0);
      burst("reburst", 8'h60);
      check_mem("reburst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
